// File: rtl/addsub_pipe.sv
// Pipelined add/subtract: one SEG-bit segment per stage, carry rippling one segment per cycle.
// Optional saturation on overflow when ADDSUB_SAT_EN is defined; NSEG must be at least 2.
module addsub_pipe #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             overflow,
    output logic             carry_out,
    output logic             zero
);

    localparam int NSEG = WIDTH / SEG;
    localparam int LAST = NSEG - 1;
    localparam logic [WIDTH-1:0] SEG_ONES = WIDTH'({SEG{1'b1}});

    // Inter-stage registers: stage k holds operands, partial sum and carry after segment k.
    logic             vld_q  [LAST];
    logic             sub_q  [LAST];
    logic             sign_q [LAST];
    logic [WIDTH-1:0] a_q    [LAST];
    logic [WIDTH-1:0] b_q    [LAST];
    logic [WIDTH-1:0] r_q    [LAST];
    logic             c_q    [LAST];

    logic             out_valid_q;
    logic [WIDTH-1:0] s_q;
    logic             ovf_q;
    logic             cout_q;
    logic             zero_q;

    logic             v_in    [NSEG];
    logic             sub_in  [NSEG];
    logic             sign_in [NSEG];
    logic [WIDTH-1:0] a_in    [NSEG];
    logic [WIDTH-1:0] b_in    [NSEG];
    logic [WIDTH-1:0] r_in    [NSEG];
    logic             cin     [NSEG];
    logic [SEG:0]     seg_w   [NSEG];
    logic [WIDTH-1:0] r_d     [NSEG];

    logic             advance;
    logic             c_last;
    logic             a_msb;
    logic             b_msb;
    logic             ovf_d;
    logic [WIDTH-1:0] s_d;
    logic             zero_d;

    assign advance = out_ready | ~out_valid_q;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign v_in[k]    = in_valid;
            assign sub_in[k]  = sub;
            assign sign_in[k] = sign;
            assign a_in[k]    = a;
            assign b_in[k]    = sub ? ~b : b;
            assign r_in[k]    = '0;
            assign cin[k]     = sub;
        end else begin : g_next
            assign v_in[k]    = vld_q[k-1];
            assign sub_in[k]  = sub_q[k-1];
            assign sign_in[k] = sign_q[k-1];
            assign a_in[k]    = a_q[k-1];
            assign b_in[k]    = b_q[k-1];
            assign r_in[k]    = r_q[k-1];
            assign cin[k]     = c_q[k-1];
        end
        assign seg_w[k] = {1'b0, a_in[k][k*SEG +: SEG]} + {1'b0, b_in[k][k*SEG +: SEG]}
                        + (SEG+1)'(cin[k]);
        assign r_d[k]   = (r_in[k] & ~(SEG_ONES << (k*SEG)))
                        | (WIDTH'(seg_w[k][SEG-1:0]) << (k*SEG));
    end

    // Flags and optional saturation are resolved while the last segment is added.
    always_comb begin
        c_last = seg_w[LAST][SEG];
        a_msb  = a_in[LAST][WIDTH-1];
        b_msb  = b_in[LAST][WIDTH-1];
        if (sign_in[LAST]) begin
            ovf_d = (a_msb == b_msb) && (r_d[LAST][WIDTH-1] != a_msb);
        end else begin
            ovf_d = sub_in[LAST] ? ~c_last : c_last;
        end
        s_d = r_d[LAST];
`ifdef ADDSUB_SAT_EN
        if (ovf_d) begin
            if (sign_in[LAST]) begin
                s_d = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                s_d = sub_in[LAST] ? '0 : '1;
            end
        end
`endif
        zero_d = (s_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LAST; k++) begin
                vld_q[k]  <= 1'b0;
                sub_q[k]  <= 1'b0;
                sign_q[k] <= 1'b0;
                a_q[k]    <= '0;
                b_q[k]    <= '0;
                r_q[k]    <= '0;
                c_q[k]    <= 1'b0;
            end
            out_valid_q <= 1'b0;
            s_q         <= '0;
            ovf_q       <= 1'b0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < LAST; k++) begin
                vld_q[k]  <= v_in[k];
                sub_q[k]  <= sub_in[k];
                sign_q[k] <= sign_in[k];
                a_q[k]    <= a_in[k];
                b_q[k]    <= b_in[k];
                r_q[k]    <= r_d[k];
                c_q[k]    <= seg_w[k][SEG];
            end
            out_valid_q <= v_in[LAST];
            s_q         <= s_d;
            ovf_q       <= ovf_d;
            cout_q      <= c_last;
            zero_q      <= zero_d;
        end
    end

    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign overflow  = ovf_q;
    assign carry_out = cout_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: arithmetic reference model on a stall-aware delay line plus literal directed cases.
// Build with ADDSUB_SAT_EN defined to check the saturating variant.
module tb_addsub_pipe;

    localparam int W  = 32;
    localparam int NS = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         sign = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] s;
    logic         overflow;
    logic         carry_out;
    logic         zero;

    addsub_pipe #(.WIDTH(W), .SEG(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .sign(sign),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .overflow(overflow), .carry_out(carry_out), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         v;
        logic [W-1:0] s;
        logic         o;
        logic         c;
        logic         z;
    } slot_t;

    slot_t m [NS];
    int checks = 0;
    int fails  = 0;
    int n_acc  = 0;
    int n_out  = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic slot_t golden(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic sb, input logic sg);
        slot_t  t;
        longint ux, uy, sx, sy, ru, rs;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'(signed'(x));
        sy = longint'(signed'(y));
        ru = sb ? ux - uy : ux + uy;
        rs = sb ? sx - sy : sx + sy;
        t.v = 1'b1;
        t.s = ru[W-1:0];
        t.c = sb ? (ux >= uy) : (ru >= 64'h1_0000_0000);
        if (sg) t.o = (rs > 64'sd2147483647) || (rs < -64'sd2147483648);
        else    t.o = sb ? (ux < uy) : t.c;
`ifdef ADDSUB_SAT_EN
        if (t.o) begin
            if (sg) t.s = (rs > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
            else    t.s = sb ? 32'h0 : 32'hFFFF_FFFF;
        end
`endif
        t.z = (t.s == '0);
        return t;
    endfunction

    // Expected output stream: a slot per pipeline stage, shifting whenever the output is free.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NS; i++) m[i] <= '0;
        end else if (out_ready || !m[NS-1].v) begin
            for (int i = NS-1; i > 0; i--) m[i] <= m[i-1];
            m[0] <= in_valid ? golden(a, b, sub, sign) : '0;
            if (in_valid) n_acc <= n_acc + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", W'(in_ready), W'(out_ready || !m[NS-1].v));
            chk("out_valid", W'(out_valid), W'(m[NS-1].v));
            if (m[NS-1].v) begin
                chk("s", s, m[NS-1].s);
                chk("overflow", W'(overflow), W'(m[NS-1].o));
                chk("carry_out", W'(carry_out), W'(m[NS-1].c));
                chk("zero", W'(zero), W'(m[NS-1].z));
            end
            if (out_valid && out_ready) n_out <= n_out + 1;
        end
    end

    // Called #1 after a rising edge with the pipeline drained and out_ready high.
    task automatic run_op(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic sb, input logic sg, input logic [W-1:0] es,
                          input logic eo, input logic ec, input logic ez);
        int n;
        bit seen;
        seen = 1'b0;
        a = x; b = y; sub = sb; sign = sg; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (n <= 12) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_latency"}, W'(n), W'(NS));
        if (seen) begin
            chk({nm, "_s"}, s, es);
            chk({nm, "_ovf"}, W'(overflow), W'(eo));
            chk({nm, "_cout"}, W'(carry_out), W'(ec));
            chk({nm, "_zero"}, W'(zero), W'(ez));
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 3))
            0:       return W'($urandom);
            1:       return 32'hFFFF_FFFF - W'($urandom_range(0, 3));
            2:       return 32'h7FFF_FFFF + W'($urandom_range(0, 2));
            default: return W'($urandom_range(0, 9));
        endcase
    endfunction

    task automatic stream(input string nm, input int nops, input bit bubbles, input int stall_at);
        int  sent, cyc, acc0, out0;
        bit  have, took;
        sent = 0; cyc = 0; have = 1'b0;
        acc0 = n_acc; out0 = n_out;
        while (sent < nops && cyc < 1000) begin
            if (!have) begin
                if (bubbles && $urandom_range(0, 1) == 1) begin
                    in_valid = 1'b0;
                end else begin
                    a = pick(); b = pick();
                    sub = 1'($urandom_range(0, 1)); sign = 1'($urandom_range(0, 1));
                    in_valid = 1'b1;
                    have = 1'b1;
                end
            end
            out_ready = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 3);
            @(negedge clk);
            took = have && in_ready;
            if (!out_ready && out_valid) chk({nm, "_stall_in_ready"}, W'(in_ready), W'(0));
            @(posedge clk); #1;
            cyc++;
            if (took) begin
                have = 1'b0;
                sent++;
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (NS + 4) begin
            @(posedge clk); #1;
        end
        chk({nm, "_accepted"}, W'(n_acc - acc0), W'(nops));
        chk({nm, "_delivered"}, W'(n_out - out0), W'(nops));
    endtask

    initial begin
        int stale;
        #1;
        chk("reset_out_valid", W'(out_valid), W'(0));
        chk("reset_s", s, W'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef ADDSUB_SAT_EN
        run_op("uadd_wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
        run_op("sadd_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_op("usub_borrow", 32'h3, 32'h5, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        run_op("ssub_neg_ovf", 32'h8000_0000, 32'h1, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
`else
        run_op("uadd_wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        run_op("sadd_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
        run_op("usub_borrow", 32'h3, 32'h5, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
        run_op("ssub_neg_ovf", 32'h8000_0000, 32'h1, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
`endif
        run_op("ssub_small", 32'h3, 32'h5, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_op("seg_carry", 32'h00FF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0);
        run_op("usub_equal", 32'h5, 32'h5, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);

        stream("b2b_stall", 8, 1'b0, 6);
        stream("bubbles", 12, 1'b1, -1);
        stream("mixed", 24, 1'b1, 9);

        // Reset with the first result at the output and two more in flight.
        for (int i = 1; i <= 3; i++) begin
            a = W'(i); b = W'(i + 10); sub = 1'b0; sign = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #2;
        chk("pre_reset_valid", W'(out_valid), W'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_reset_out_valid", W'(out_valid), W'(0));
        chk("mid_reset_s", s, W'(0));
        chk("mid_reset_flags", W'({overflow, carry_out, zero}), W'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale++;
            @(posedge clk); #1;
        end
        chk("no_stale_result", W'(stale), W'(0));
        run_op("after_reset", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
